// File: rtl/uart_tx.sv
// UART transmit engine: pops one byte from the FIFO and serializes it as
// start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
// Every serial bit lasts OVERSAMPLE baudClk cycles.
module uart_tx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       baudClk,
  input  logic       reset,
  input  logic       empty,
  input  logic [7:0] data_in,
  output logic       rd,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                bit_end;

  // State, counters, shift register and line driver; all return to idle on reset.
  always_ff @(posedge baudClk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx is computed one cycle ahead so the line is registered.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd      = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;

    bit_end = (tick_q == TICK_LAST);
    tick_d  = bit_end ? '0 : tick_q + TICK_W'(1);

    unique case (state_q)
      IDLE: begin
        busy   = 1'b0;
        tick_d = '0;
        tx_d   = 1'b1;
        if (!empty) state_d = LOAD;
      end
      LOAD: begin
        rd      = 1'b1;
        tick_d  = '0;
        bit_d   = '0;
        shift_d = data_in;
        par_d   = (^data_in) ^ PARITY_ODD;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        // bit_q counts stop bits here so done lands only on the final one
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            done    = 1'b1;
            bit_d   = '0;
            state_d = empty ? IDLE : LOAD;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: several parameterisations, a FIFO model
// feeding each, and a frame-level reference model of the serial waveform.
module tb_uart_tx;

  localparam int N = 5;
  localparam int OS_A  [N] = '{16, 16, 16, 16, 2};
  localparam int PEN_A [N] = '{0, 1, 1, 0, 1};
  localparam int ODD_A [N] = '{0, 0, 1, 0, 1};
  localparam int STB_A [N] = '{1, 1, 1, 2, 2};

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] empty;
  logic [7:0]   din [N];
  logic [N-1:0] rd_w, tx_w, busy_w, done_w;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] byte_q [$];
  logic [3:0] exp_q [$];
  logic       pop_pending;

  always #5 clk = ~clk;

  uart_tx #(.OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (
    .baudClk(clk), .reset(reset), .empty(empty[0]), .data_in(din[0]),
    .rd(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx #(.OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u1 (
    .baudClk(clk), .reset(reset), .empty(empty[1]), .data_in(din[1]),
    .rd(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx #(.OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (
    .baudClk(clk), .reset(reset), .empty(empty[2]), .data_in(din[2]),
    .rd(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx #(.OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u3 (
    .baudClk(clk), .reset(reset), .empty(empty[3]), .data_in(din[3]),
    .rd(rd_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));
  uart_tx #(.OVERSAMPLE(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u4 (
    .baudClk(clk), .reset(reset), .empty(empty[4]), .data_in(din[4]),
    .rd(rd_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .done(done_w[4]));

  function automatic logic [3:0] obs(input int k);
    return {rd_w[k], tx_w[k], busy_w[k], done_w[k]};
  endfunction

  // Expected {rd,tx,busy,done} per cycle for every byte in byte_q, sent back to back.
  task automatic build_expected(input int k, input int idle_tail);
    int bits [$];
    int ones;
    logic [7:0] b;
    exp_q.delete();
    for (int n = 0; n < byte_q.size(); n++) begin
      b = byte_q[n];
      bits.delete();
      bits.push_back(0);
      for (int i = 0; i < 8; i++) bits.push_back((int'(b) >> i) % 2);
      if (PEN_A[k] != 0) begin
        ones = $countones(b);
        if (ODD_A[k] != 0) bits.push_back((ones % 2 == 0) ? 1 : 0);
        else               bits.push_back((ones % 2 == 1) ? 1 : 0);
      end
      for (int s = 0; s < STB_A[k]; s++) bits.push_back(1);
      exp_q.push_back(4'b1110);
      for (int j = 0; j < bits.size(); j++)
        for (int t = 0; t < OS_A[k]; t++)
          exp_q.push_back({1'b0, bits[j] != 0, 1'b1,
                           (j == bits.size() - 1) && (t == OS_A[k] - 1)});
    end
    for (int i = 0; i < idle_tail; i++) exp_q.push_back(4'b0100);
  endtask

  task automatic drive_fifo(input int k);
    empty[k] = (byte_q.size() == 0);
    din[k]   = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
  endtask

  // Offers byte_q to instance k and checks every cycle against the model.
  task automatic run_check(input string name, input int k, input int limit,
                           output int rd_cnt, output int busy_cnt);
    logic [3:0] got;
    build_expected(k, 4);
    rd_cnt = 0;
    busy_cnt = 0;
    pop_pending = 1'b0;
    @(posedge clk); #1;
    drive_fifo(k);
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      @(posedge clk); #1;
      if (pop_pending) begin
        if (byte_q.size() != 0) void'(byte_q.pop_front());
        pop_pending = 1'b0;
        drive_fifo(k);
      end
      got = obs(k);
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s inst%0d cycle %0d {rd,tx,busy,done}: got %b expected %b",
                 name, k, i, got, exp_q[i]);
      end
      if (rd_w[k] === 1'b1) begin
        pop_pending = 1'b1;
        rd_cnt++;
      end
      if (busy_w[k] === 1'b1) busy_cnt++;
    end
  endtask

  task automatic check_count(input string name, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    empty = '1;
    for (int k = 0; k < N; k++) din[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (obs(k) !== 4'b0100) begin
        n_fail++;
        $display("FAIL reset_state inst%0d {rd,tx,busy,done}: got %b expected 0100", k, obs(k));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_byte();
    int rc, bc;
    byte_q = '{8'hA5};
    run_check("single_a5", 0, 1 << 30, rc, bc);
    check_count("single_rd_pulses", rc, 1);
    check_count("single_busy_cycles", bc, 161);
  endtask

  task automatic test_back_to_back();
    int rc, bc;
    byte_q = '{8'h55, 8'h0F};
    run_check("b2b", 0, 1 << 30, rc, bc);
    check_count("b2b_rd_pulses", rc, 2);
    check_count("b2b_busy_cycles", bc, 2 * 160 + 2);
  endtask

  task automatic test_empty_fifo();
    int bad;
    bad = 0;
    empty = '1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (obs(0) !== 4'b0100) bad++;
    end
    check_count("empty_idle_violations", bad, 0);
  endtask

  task automatic test_parity();
    int rc, bc;
    byte_q = '{8'h07};
    run_check("parity_even_07", 1, 1 << 30, rc, bc);
    check_count("parity_even_busy", bc, 177);
    byte_q = '{8'h07};
    run_check("parity_odd_07", 2, 1 << 30, rc, bc);
    check_count("parity_odd_busy", bc, 177);
  endtask

  task automatic test_two_stop();
    int rc, bc;
    byte_q = '{8'hFF};
    run_check("two_stop_ff", 3, 1 << 30, rc, bc);
    check_count("two_stop_busy", bc, 177);
  endtask

  task automatic test_random();
    int rc, bc, nb;
    int ks [2] = '{0, 4};
    for (int r = 0; r < 8; r++) begin
      byte_q.delete();
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) byte_q.push_back(8'($urandom_range(0, 255)));
      run_check("random", ks[r % 2], 1 << 30, rc, bc);
      check_count("random_rd_pulses", rc, nb);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rc, bc;
    byte_q = '{8'h3C};
    // LOAD + start bit + bits 0..2 + 6 cycles into data bit 3
    run_check("midreset_pre", 0, 1 + 16 + 48 + 6, rc, bc);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs(0) !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_async {rd,tx,busy,done}: got %b expected 0100", obs(0));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (obs(0) !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_held {rd,tx,busy,done}: got %b expected 0100", obs(0));
    end
    reset = 1'b0;
    pop_pending = 1'b0;
    byte_q = '{8'h81};
    run_check("post_reset_81", 0, 1 << 30, rc, bc);
    check_count("post_reset_rd_pulses", rc, 1);
  endtask

  initial begin
    reset = 1'b1;
    empty = '1;
    pop_pending = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty_fifo();
    test_parity();
    test_two_stop();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit engine that drains the byte FIFO and serializes each byte onto the serial line as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It sits on the FIFO read side. It watches the FIFO's empty flag, pops one byte with a single-cycle rd pulse, and drives tx. It runs on the same oversampled baudClk as the FIFO.

Parameters:
OVERSAMPLE, 16, baudClk cycles per serial bit (legal range 2..256)
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, with PARITY_EN=1: 0 selects even parity, 1 selects odd parity
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
baudClk  input  1  clock; every register updates on its rising edge
reset  input  1  asynchronous, active-high; forces every register to its reset value immediately
empty  input  1  FIFO empty flag
data_in  input  8  FIFO read data; combinational, valid for the current read pointer while empty=0
rd  output  1  FIFO pop request; one-cycle pulse
tx  output  1  serial line output; registered; idle level is 1
busy  output  1  high whenever a frame is being fetched or transmitted
done  output  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Reset values: state=IDLE, tx=1, rd=0, busy=0, done=0, tick counter=0, bit counter=0, shift register=0.
- FSM states: IDLE, LOAD, START, DATA, PARITY, STOP.
- Each of START, DATA (per bit), PARITY and STOP (per stop bit) lasts exactly OVERSAMPLE cycles. A tick counter runs 0..OVERSAMPLE-1 and clears on every bit boundary.
- IDLE: tx=1, busy=0. If empty=0 at a rising edge, the next state is LOAD.
- LOAD (exactly 1 cycle):
  - rd=1, decoded from the state.
  - At the edge leaving LOAD, shift register <= data_in and the FIFO advances its read pointer at the same edge.
  - The parity accumulator is loaded from data_in at that edge: XOR-reduce of data_in, XORed with PARITY_ODD.
  - The next state is START and tx becomes 0 at that edge.
- START: tx=0. After OVERSAMPLE cycles, go to DATA with tx=shift[0] and bit counter=0.
- DATA:
  - Each bit boundary shifts right and increments the bit counter.
  - After bit 7 completes, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx=parity bit for OVERSAMPLE cycles, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*OVERSAMPLE cycles.
  - done=1 in the last cycle of the final stop bit.
  - At the closing edge, go to LOAD if empty=0, else go to IDLE.
- Back-to-back frames: there is exactly one idle-high cycle (the LOAD cycle) between the last stop bit and the next start bit.
- busy=1 in every state except IDLE.
- rd is never asserted while empty=1. rd is asserted at most once per frame.
- Frame length, from the edge entering START to the next return to IDLE/LOAD: (10 + PARITY_EN + STOP_BITS - 1) * OVERSAMPLE cycles.
- Latency: the first edge that sees empty=0 in IDLE enters LOAD. The next edge drives tx low. So tx goes low 2 edges after empty is first sampled low.
- Changes on empty or data_in during START, DATA, PARITY or STOP are ignored. The shift register is the only data source.
- Reset mid-frame:
  - Immediately: tx=1, rd=0, busy=0, done=0, state=IDLE.
  - The byte already popped is lost.
  - No partial frame continues after reset deasserts.
- Counter widths: the tick counter is clog2(OVERSAMPLE) bits and the bit counter is 3 bits. Neither counter ever wraps mid-bit.

Test Plan:
- Single byte: OVERSAMPLE=16, push 0xA5, empty drops.
  - Expect one rd pulse and tx low 2 edges later for 16 cycles.
  - Expect data bits 1,0,1,0,0,1,0,1, 16 cycles each, then 16 cycles high with done pulsing in the last one, then IDLE and busy=0.
- Back-to-back: queue 0x55 then 0x0F.
  - Expect exactly 2 rd pulses and 1 high cycle between the stop bit of 0x55 and the start bit of 0x0F.
  - Expect busy held high across both frames and a total of 2*160+2 cycles from the first LOAD.
- Empty FIFO: empty held at 1 for 1000 cycles -> rd=0, tx=1, busy=0 and done=0 throughout.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. Repeat with PARITY_ODD=1 -> parity bit 0. Frame is 176 cycles.
- Two stop bits: STOP_BITS=2, send 0xFF -> tx stays high for 32 cycles after the last data bit before done pulses.
- Reset mid-frame: assert reset during data bit 3 of 0x3C.
  - tx=1 and busy=0 before the next clock edge.
  - After release with empty=0, the next frame starts with a fresh LOAD and a full start bit.
